// File: rtl/tile_draw_sequencer_pkg.sv
// Shared types and constants for the frame draw sequencer: FSM states,
// pixel colours, play-field bounds and the lane-id to column mapping.
package tile_draw_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    TILE_SEL,
    TILE_RUN,
    TILE_REL,
    MISS_RUN,
    MISS_REL,
    DONE
  } state_t;

  localparam logic [2:0] BG_COLOUR_DEF   = 3'b111;
  localparam logic [2:0] TILE_COLOUR_DEF = 3'b000;
  localparam logic [2:0] MISS_COLOUR_DEF = 3'b100;

  localparam int unsigned FIELD_X0_DEF = 120;
  localparam int unsigned FIELD_X1_DEF = 199;
  localparam int unsigned FIELD_Y1_DEF = 239;
  localparam int unsigned LANE_WIDTH   = 20;

  // Lanes 1..4 map to 20-pixel columns starting at the field's left edge.
  function automatic logic [8:0] lane_x0(input logic [2:0] id);
    if (id >= 3'd1 && id <= 3'd4)
      return 9'(FIELD_X0_DEF + LANE_WIDTH * (int'(id) - 1));
    return 9'(FIELD_X0_DEF);
  endfunction

endpackage

// File: rtl/tile_draw_sequencer_if.sv
// Bundle of frame-request, painter handshake and VGA pixel-stream signals
// seen by the draw sequencer; master is the sequencer side.
interface tile_draw_sequencer_if #(
  parameter int unsigned NUM_TILES = 4
);
  logic                   frame_tick;
  logic [NUM_TILES-1:0]   tile_valid;
  logic [3*NUM_TILES-1:0] tile_line;
  logic [6*NUM_TILES-1:0] tile_offset;
  logic                   miss_valid;
  logic [2:0]             miss_lane;
  logic                   block_done;
  logic [8:0]             block_x;
  logic [7:0]             block_y;
  logic                   line_done;
  logic [8:0]             line_x;
  logic [7:0]             line_y;
  logic                   block_go;
  logic [2:0]             block_line_id;
  logic [5:0]             block_offset;
  logic                   line_go;
  logic [2:0]             line_id;
  logic [8:0]             vga_x;
  logic [7:0]             vga_y;
  logic [2:0]             vga_colour;
  logic                   vga_plot;
  logic                   busy;
  logic                   frame_done;

  modport master (
    input  frame_tick, tile_valid, tile_line, tile_offset, miss_valid, miss_lane,
    input  block_done, block_x, block_y, line_done, line_x, line_y,
    output block_go, block_line_id, block_offset, line_go, line_id,
    output vga_x, vga_y, vga_colour, vga_plot, busy, frame_done
  );

  modport slave (
    output frame_tick, tile_valid, tile_line, tile_offset, miss_valid, miss_lane,
    output block_done, block_x, block_y, line_done, line_x, line_y,
    input  block_go, block_line_id, block_offset, line_go, line_id,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, frame_done
  );
endinterface

// File: rtl/tile_draw_sequencer_field_clear_scan.sv
// Raster counter for the play-field clear: walks x across the field, then
// advances y, flagging the final bottom-right pixel.
module field_clear_scan #(
  parameter int unsigned X0 = 120,
  parameter int unsigned X1 = 199,
  parameter int unsigned Y1 = 239
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  output logic [8:0] cx,
  output logic [7:0] cy,
  output logic       last
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
    end else if (start) begin
      cx <= 9'(X0);
      cy <= '0;
    end else if (step) begin
      if (cx == 9'(X1)) begin
        cx <= 9'(X0);
        cy <= cy + 8'd1;
      end else begin
        cx <= cx + 9'd1;
      end
    end
  end

  always_comb last = (cx == 9'(X1)) && (cy == 8'(Y1));

endmodule

// File: rtl/tile_draw_sequencer.sv
// Per-frame draw controller: snapshots the tile list, clears the field, runs
// the block painter per valid tile and the lane painter for a miss.
module tile_draw_sequencer
  import tile_draw_sequencer_pkg::*;
#(
  parameter int unsigned NUM_TILES   = 4,
  parameter logic [2:0]  BG_COLOUR   = BG_COLOUR_DEF,
  parameter logic [2:0]  TILE_COLOUR = TILE_COLOUR_DEF,
  parameter logic [2:0]  MISS_COLOUR = MISS_COLOUR_DEF,
  parameter int unsigned FIELD_X0    = FIELD_X0_DEF,
  parameter int unsigned FIELD_X1    = FIELD_X1_DEF,
  parameter int unsigned FIELD_Y1    = FIELD_Y1_DEF
) (
  input logic                  clock,
  input logic                  reset,
  tile_draw_sequencer_if.master bus
);

  localparam int unsigned SLOT_W = $clog2(NUM_TILES + 1);

  state_t                 state;
  logic [SLOT_W-1:0]      slot;
  logic [NUM_TILES-1:0]   snap_valid;
  logic [3*NUM_TILES-1:0] snap_line;
  logic [6*NUM_TILES-1:0] snap_offset;
  logic                   snap_miss;
  logic [2:0]             snap_miss_lane;

  logic       cur_valid;
  logic [2:0] cur_line;
  logic [5:0] cur_offset;
  logic [8:0] cx;
  logic [7:0] cy;
  logic       clear_last;

  field_clear_scan #(
    .X0(FIELD_X0),
    .X1(FIELD_X1),
    .Y1(FIELD_Y1)
  ) u_clear (
    .clock (clock),
    .reset (reset),
    .start (state == IDLE && bus.frame_tick),
    .step  (state == CLEAR),
    .cx    (cx),
    .cy    (cy),
    .last  (clear_last)
  );

  // Slot index reaches NUM_TILES once the scan has passed the last slot.
  always_comb begin
    cur_valid  = 1'b0;
    cur_line   = '0;
    cur_offset = '0;
    for (int unsigned i = 0; i < NUM_TILES; i++) begin
      if (SLOT_W'(i) == slot) begin
        cur_valid  = snap_valid[i];
        cur_line   = snap_line[3*i +: 3];
        cur_offset = snap_offset[6*i +: 6];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      slot              <= '0;
      snap_valid        <= '0;
      snap_line         <= '0;
      snap_offset       <= '0;
      snap_miss         <= 1'b0;
      snap_miss_lane    <= '0;
      bus.block_go      <= 1'b0;
      bus.block_line_id <= '0;
      bus.block_offset  <= '0;
      bus.line_go       <= 1'b0;
      bus.line_id       <= '0;
      bus.busy          <= 1'b0;
      bus.frame_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.frame_tick) begin
            snap_valid     <= bus.tile_valid;
            snap_line      <= bus.tile_line;
            snap_offset    <= bus.tile_offset;
            snap_miss      <= bus.miss_valid;
            snap_miss_lane <= bus.miss_lane;
            slot           <= '0;
            bus.busy       <= 1'b1;
            state          <= CLEAR;
          end
        end
        CLEAR: begin
          if (clear_last) state <= TILE_SEL;
        end
        TILE_SEL: begin
          if (slot == SLOT_W'(NUM_TILES)) begin
            if (snap_miss) begin
              bus.line_go <= 1'b1;
              bus.line_id <= snap_miss_lane;
              state       <= MISS_RUN;
            end else begin
              bus.frame_done <= 1'b1;
              state          <= DONE;
            end
          end else if (cur_valid) begin
            bus.block_line_id <= cur_line;
            bus.block_offset  <= cur_offset;
            bus.block_go      <= 1'b1;
            state             <= TILE_RUN;
          end else begin
            slot <= slot + SLOT_W'(1);
          end
        end
        TILE_RUN: begin
          if (bus.block_done) begin
            bus.block_go <= 1'b0;
            state        <= TILE_REL;
          end
        end
        TILE_REL: begin
          slot  <= slot + SLOT_W'(1);
          state <= TILE_SEL;
        end
        MISS_RUN: begin
          if (bus.line_done) begin
            bus.line_go <= 1'b0;
            state       <= MISS_REL;
          end
        end
        MISS_REL: begin
          bus.frame_done <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          bus.frame_done <= 1'b0;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The go registers are high exactly during their RUN states, so painter
  // pixels pass through with no added latency.
  always_comb begin
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    bus.vga_plot   = 1'b0;
    if (state == CLEAR) begin
      bus.vga_x      = cx;
      bus.vga_y      = cy;
      bus.vga_colour = BG_COLOUR;
      bus.vga_plot   = 1'b1;
    end else if (bus.block_go) begin
      bus.vga_x      = bus.block_x;
      bus.vga_y      = bus.block_y;
      bus.vga_colour = TILE_COLOUR;
      bus.vga_plot   = ~bus.block_done;
    end else if (bus.line_go) begin
      bus.vga_x      = bus.line_x;
      bus.vga_y      = bus.line_y;
      bus.vga_colour = MISS_COLOUR;
      bus.vga_plot   = ~bus.line_done;
    end
  end

endmodule

// File: tb/tb_tile_draw_sequencer.sv
// Bench for tile_draw_sequencer: frame vectors from a table plus a random
// frame, checked against a pixel-stream model built from the drawing rules.
module tb_tile_draw_sequencer;
  import tile_draw_sequencer_pkg::*;

  localparam int unsigned NT       = 4;
  localparam int unsigned WAIT_MAX = 25000;

  typedef struct {
    logic [NT-1:0]   valid;
    logic [3*NT-1:0] line;
    logic [6*NT-1:0] offset;
    logic            miss;
    logic [2:0]      lane;
    int unsigned     plen;
    int unsigned     mlen;
    bit              disturb;
    int unsigned     exp_blk;
    int unsigned     exp_ln;
  } frame_vec_t;

  typedef logic [19:0] pix_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tile_draw_sequencer_if #(.NUM_TILES(NT)) bus ();
  tile_draw_sequencer #(.NUM_TILES(NT)) dut (.clock(clock), .reset(reset), .bus(bus));

  // Painter models: k-th go cycle emits pixel k, done once k reaches the length.
  int unsigned plen = 0, mlen = 0, blk_k = 0, ln_k = 0;
  always @(posedge clock) begin
    blk_k <= bus.block_go ? blk_k + 1 : 0;
    ln_k  <= bus.line_go ? ln_k + 1 : 0;
  end
  assign bus.block_done = bus.block_go && (blk_k >= plen);
  assign bus.block_x    = lane_x0(bus.block_line_id) + 9'(blk_k);
  assign bus.block_y    = 8'(bus.block_offset) + 8'(blk_k);
  assign bus.line_done  = bus.line_go && (ln_k >= mlen);
  assign bus.line_x     = lane_x0(bus.line_id) + 9'(ln_k);
  assign bus.line_y     = 8'(ln_k);

  int checks = 0, errors = 0;
  pix_t exp_q[$];
  logic [8:0] exp_blk_q[$], obs_blk[$];
  logic [2:0] exp_ln_q[$], obs_ln[$];
  bit mon_en = 0, prev_bgo = 0, prev_lgo = 0;
  int unsigned plot_cnt, pix_err, id_unstable, both_err, done_cnt;
  pix_t bad_got, bad_want;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic sample();
    pix_t got, want;
    if (mon_en) begin
      if (bus.vga_plot) begin
        plot_cnt++;
        got  = {bus.vga_x, bus.vga_y, bus.vga_colour};
        want = '1;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        if (got !== want) begin
          if (pix_err == 0) begin
            bad_got  = got;
            bad_want = want;
          end
          pix_err++;
        end
      end
      if (bus.block_go && !prev_bgo)
        obs_blk.push_back({bus.block_line_id, bus.block_offset});
      else if (bus.block_go && obs_blk.size() > 0 && obs_blk[$] !== {bus.block_line_id, bus.block_offset})
        id_unstable++;
      if (bus.line_go && !prev_lgo) obs_ln.push_back(bus.line_id);
      if (bus.block_go && bus.line_go) both_err++;
      if (bus.frame_done) done_cnt++;
    end
    prev_bgo = bus.block_go;
    prev_lgo = bus.line_go;
  endtask

  task automatic step();
    @(negedge clock);
    sample();
  endtask

  // Expected frame: full raster of background, then each valid slot's
  // painter pixels in slot order, then the miss lane's pixels.
  task automatic build_model(input frame_vec_t v);
    logic [2:0] ln;
    logic [5:0] off;
    exp_q.delete();
    exp_blk_q.delete();
    exp_ln_q.delete();
    for (int y = 0; y <= 239; y++)
      for (int x = 120; x <= 199; x++)
        exp_q.push_back({9'(x), 8'(y), 3'b111});
    for (int i = 0; i < int'(NT); i++) begin
      if (v.valid[i]) begin
        ln  = v.line[3*i +: 3];
        off = v.offset[6*i +: 6];
        exp_blk_q.push_back({ln, off});
        for (int k = 0; k < int'(v.plen); k++)
          exp_q.push_back({lane_x0(ln) + 9'(k), 8'(off) + 8'(k), 3'b000});
      end
    end
    if (v.miss) begin
      exp_ln_q.push_back(v.lane);
      for (int k = 0; k < int'(v.mlen); k++)
        exp_q.push_back({lane_x0(v.lane) + 9'(k), 8'(k), 3'b100});
    end
  endtask

  task automatic run_frame(input frame_vec_t v);
    int unsigned cyc, exp_plots;
    build_model(v);
    exp_plots = exp_q.size();
    plen = v.plen;
    mlen = v.mlen;
    plot_cnt = 0; pix_err = 0; id_unstable = 0; both_err = 0; done_cnt = 0;
    obs_blk.delete();
    obs_ln.delete();
    bus.tile_valid  = v.valid;
    bus.tile_line   = v.line;
    bus.tile_offset = v.offset;
    bus.miss_valid  = v.miss;
    bus.miss_lane   = v.lane;
    bus.frame_tick  = 1'b1;
    mon_en = 1;
    step();
    bus.frame_tick = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 1);
    if (v.disturb) begin
      // Snapshot inputs scrambled and extra ticks issued while busy.
      bus.tile_valid  = ~v.valid;
      bus.tile_line   = ~v.line;
      bus.tile_offset = ~v.offset;
      bus.miss_valid  = ~v.miss;
      bus.miss_lane   = ~v.lane;
      repeat (50) step();
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      cyc = 0;
      while (!bus.block_go && cyc < WAIT_MAX) begin step(); cyc++; end
      check("reach_tile_run", 32'(bus.block_go), 1);
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
    end
    cyc = 0;
    while (!bus.frame_done && cyc < WAIT_MAX) begin step(); cyc++; end
    check("frame_done_seen", 32'(bus.frame_done), 1);
    step();
    check("frame_done_width", 32'(bus.frame_done), 0);
    check("busy_after_done", 32'(bus.busy), 0);
    repeat (20) step();
    mon_en = 0;
    check("frame_done_count", done_cnt, 1);
    check("plot_count", plot_cnt, exp_plots);
    checks++;
    if (pix_err != 0) begin
      errors++;
      $display("FAIL pixel_stream: %0d bad pixels, first got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
               pix_err, bad_got[19:11], bad_got[10:3], bad_got[2:0],
               bad_want[19:11], bad_want[10:3], bad_want[2:0]);
    end
    check("block_pulses", obs_blk.size(), v.exp_blk);
    for (int i = 0; i < exp_blk_q.size() && i < obs_blk.size(); i++)
      check($sformatf("block_id_offset_%0d", i), 32'(obs_blk[i]), 32'(exp_blk_q[i]));
    check("line_pulses", obs_ln.size(), v.exp_ln);
    for (int i = 0; i < exp_ln_q.size() && i < obs_ln.size(); i++)
      check($sformatf("line_id_%0d", i), 32'(obs_ln[i]), 32'(exp_ln_q[i]));
    check("block_id_stable", id_unstable, 0);
    check("go_exclusive", both_err, 0);
    check("idle_plot", 32'(bus.vga_plot), 0);
  endtask

  frame_vec_t tbl[2];
  frame_vec_t rv;
  int unsigned cyc, done_seen;

  initial begin
    bus.frame_tick  = 1'b0;
    bus.tile_valid  = '0;
    bus.tile_line   = '0;
    bus.tile_offset = '0;
    bus.miss_valid  = 1'b0;
    bus.miss_lane   = '0;

    // Table: empty frame, then two tiles plus a miss with mid-frame disturbances.
    tbl[0].valid = '0; tbl[0].line = '0; tbl[0].offset = '0;
    tbl[0].miss = 1'b0; tbl[0].lane = 3'd0; tbl[0].plen = 3; tbl[0].mlen = 3;
    tbl[0].disturb = 0; tbl[0].exp_blk = 0; tbl[0].exp_ln = 0;
    tbl[1].valid = 4'b0101;
    tbl[1].line = '0;
    tbl[1].line[2:0] = 3'd1; tbl[1].line[5:3] = 3'd2; tbl[1].line[8:6] = 3'd4; tbl[1].line[11:9] = 3'd3;
    tbl[1].offset = '0;
    tbl[1].offset[5:0] = 6'd10; tbl[1].offset[11:6] = 6'd55; tbl[1].offset[17:12] = 6'd0; tbl[1].offset[23:18] = 6'd7;
    tbl[1].miss = 1'b1; tbl[1].lane = 3'd3; tbl[1].plen = 5; tbl[1].mlen = 4;
    tbl[1].disturb = 1; tbl[1].exp_blk = 2; tbl[1].exp_ln = 1;

    repeat (3) step();
    check("rst_block_go", 32'(bus.block_go), 0);
    check("rst_line_go", 32'(bus.line_go), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_vga_plot", 32'(bus.vga_plot), 0);
    check("rst_vga_xy", {bus.vga_x, bus.vga_y}, 0);
    check("rst_ids", {bus.block_line_id, bus.block_offset, bus.line_id}, 0);
    reset = 1'b0;
    repeat (2) step();

    for (int t = 0; t < 2; t++) run_frame(tbl[t]);

    // Reset asserted mid-TILE_RUN must drop go/plot/busy between clock edges.
    plen = 40;
    mlen = 2;
    bus.tile_valid  = 4'b0010;
    bus.tile_line   = 12'h0010;
    bus.tile_offset = 24'h000840;
    bus.miss_valid  = 1'b1;
    bus.miss_lane   = 3'd4;
    bus.frame_tick  = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    cyc = 0;
    while (!bus.block_go && cyc < WAIT_MAX) begin step(); cyc++; end
    check("rst_reach_tile_run", 32'(bus.block_go), 1);
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    check("async_block_go", 32'(bus.block_go), 0);
    check("async_vga_plot", 32'(bus.vga_plot), 0);
    check("async_busy", 32'(bus.busy), 0);
    step();
    step();
    reset = 1'b0;
    done_seen = 0;
    repeat (30) begin
      step();
      if (bus.frame_done || bus.line_go || bus.block_go) done_seen++;
    end
    check("no_activity_after_reset", done_seen, 0);

    // Random frame: done-on-first-go block painter, random-length lane painter.
    rv.valid = 4'($urandom_range(1, 15));
    rv.line = '0;
    rv.offset = '0;
    for (int i = 0; i < int'(NT); i++) begin
      rv.line[3*i +: 3]   = 3'($urandom_range(1, 4));
      rv.offset[6*i +: 6] = 6'($urandom);
    end
    rv.miss = 1'($urandom_range(0, 1));
    rv.lane = 3'($urandom_range(1, 4));
    rv.plen = 0;
    rv.mlen = $urandom_range(0, 3);
    rv.disturb = 0;
    rv.exp_blk = 0;
    for (int i = 0; i < int'(NT); i++) if (rv.valid[i]) rv.exp_blk++;
    rv.exp_ln = rv.miss ? 1 : 0;
    run_frame(rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
